// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: start bit, DBIT data bits LSB first, stop bit.
// Samples the centre of each bit using the baud generator's s_tick strobe; reports each frame with a one-clk done pulse.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [4:0] MID_START = 5'd7;
    localparam logic [4:0] MID_BIT   = 5'd15;
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

    state_t          state, state_next;
    logic [4:0]      s, s_next;
    logic [2:0]      n, n_next;
    logic [DBIT-1:0] b, b_next;
    logic [DBIT-1:0] dout_next;
    logic            frame_err_next;
    logic            done_next;
    logic            rx_meta, rx_s;

    // Synchroniser flops reset to 1 so that reset looks like an idle line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking so each flop samples the pre-edge value of the one before it.
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            dout         <= '0;
            frame_err    <= 1'b0;
            rx_done_tick <= 1'b0;
        end else begin
            state        <= state_next;
            s            <= s_next;
            n            <= n_next;
            b            <= b_next;
            dout         <= dout_next;
            frame_err    <= frame_err_next;
            rx_done_tick <= done_next;
        end
    end

    always_comb begin
        // NOTE: every output takes a hold/default value first so no path infers a latch.
        state_next     = state;
        s_next         = s;
        n_next         = n;
        b_next         = b;
        dout_next      = dout;
        frame_err_next = frame_err;
        done_next      = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == MID_START) begin
                        // A start bit that is high again at its centre was a glitch.
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == MID_BIT) begin
                        s_next = '0;
                        b_next = {rx_s, b[DBIT-1:1]};
                        if (n == N_LAST) state_next = STOP;
                        else             n_next     = n + 3'd1;
                    end else begin
                        s_next = s + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == STOP_LAST) begin
                        state_next     = IDLE;
                        dout_next      = b;
                        frame_err_next = ~rx_s;
                        done_next      = 1'b1;
                    end else begin
                        s_next = s + 5'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: frames are driven on the line tick by tick and the
// received words, error flags and done-tick timing are compared with a frame-level model.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx7 = 1'b1;
    logic       s_tick = 1'b0;
    logic [7:0] dout;
    logic       rx_done_tick, frame_err;
    logic [6:0] dout7;
    logic       done7, ferr7;

    uart_rx dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx           (rx),
        .s_tick       (s_tick),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err)
    );

    uart_rx #(.DBIT(7), .SB_TICK(32)) dut7 (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx           (rx7),
        .s_tick       (s_tick),
        .dout         (dout7),
        .rx_done_tick (done7),
        .frame_err    (ferr7)
    );

    always #5 clk = ~clk;

    // s_tick: one clk wide every 4 clk, changed on the falling edge.
    int div = 0;
    always @(negedge clk) begin
        div    = (div + 1) % 4;
        s_tick = (div == 0);
    end

    int tick_cnt = 0;
    always @(posedge clk) if (s_tick) tick_cnt <= tick_cnt + 1;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        int         tick;
    } frame_t;

    frame_t got8[$], got7[$], exp8[$], exp7[$];
    int     wide_pulses = 0;
    logic   prev_done = 1'b0;
    logic [7:0] model_dout = 8'h00;
    logic       model_ferr = 1'b0;

    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) got8.push_back('{dout, frame_err, tick_cnt});
        if (done7 === 1'b1)        got7.push_back('{{1'b0, dout7}, ferr7, tick_cnt});
        if (rx_done_tick === 1'b1 && prev_done === 1'b1) wide_pulses++;
        prev_done = rx_done_tick;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic wait_tick();
        do @(posedge clk); while (s_tick !== 1'b1);
        #1;
    endtask

    task automatic drive(input logic v, input int nticks, input bit sel7);
        if (sel7) rx7 = v;
        else      rx  = v;
        repeat (nticks) wait_tick();
    endtask

    // Model: a frame starting just after tick T is sampled mid start bit at T+8,
    // each data bit 16 ticks later, and completes SB_TICK ticks after the last data sample.
    task automatic send_frame(input logic [7:0] data, input int nbits, input int sb,
                              input bit stop_ok, input bit sel7);
        int         start;
        logic [7:0] mask;
        start = tick_cnt;
        mask  = 8'((1 << nbits) - 1);
        drive(1'b0, 16, sel7);
        for (int i = 0; i < nbits; i++) drive(data[i], 16, sel7);
        if (stop_ok) begin
            drive(1'b1, sb, sel7);
        end else begin
            drive(1'b0, sb - 4, sel7);
            drive(1'b1, 4, sel7);
        end
        if (sel7) exp7.push_back('{data & mask, !stop_ok, start + 8 + 16 * nbits + sb});
        else begin
            exp8.push_back('{data & mask, !stop_ok, start + 8 + 16 * nbits + sb});
            model_dout = data & mask;
            model_ferr = !stop_ok;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (dout !== 8'h00 || frame_err !== 1'b0 || rx_done_tick !== 1'b0)
            $display("FAIL reset_outputs: dout=%h ferr=%b done=%b, want 00/0/0", dout, frame_err, rx_done_tick);
        else n_pass++;
        n_checks++;
        if (dout7 !== 7'h00 || ferr7 !== 1'b0 || done7 !== 1'b0)
            $display("FAIL reset_outputs7: dout=%h ferr=%b done=%b, want 00/0/0", dout7, ferr7, done7);
        else n_pass++;
        reset_n = 1'b1;
        wait_tick();
        drive(1'b1, 20, 1'b0);
        n_checks++;
        if (got8.size() !== 0) $display("FAIL idle_no_done: %0d pulses, want 0", got8.size());
        else n_pass++;
        got8.delete();
    endtask

    task automatic test_basic();
        wait_tick();
        send_frame(8'hA5, 8, 16, 1'b1, 1'b0);
        drive(1'b1, 16, 1'b0);
        n_checks++;
        if (got8.size() !== 1) $display("FAIL basic_count: %0d pulses, want 1", got8.size());
        else n_pass++;
        if (got8.size() > 0) begin
            n_checks++;
            if (got8[0].data !== 8'hA5 || got8[0].ferr !== 1'b0 || got8[0].tick !== exp8[0].tick)
                $display("FAIL basic_frame: data=%h ferr=%b tick=%0d, want A5/0/%0d",
                         got8[0].data, got8[0].ferr, got8[0].tick, exp8[0].tick);
            else n_pass++;
        end
        got8.delete(); exp8.delete();
    endtask

    task automatic test_glitch();
        logic [7:0] d;
        wait_tick();
        drive(1'b0, 5, 1'b0);
        drive(1'b1, 24, 1'b0);
        n_checks++;
        if (got8.size() !== 0 || dout !== model_dout)
            $display("FAIL glitch_reject: pulses=%0d dout=%h, want 0/%h", got8.size(), dout, model_dout);
        else n_pass++;
        d = 8'($urandom);
        send_frame(d, 8, 16, 1'b1, 1'b0);
        drive(1'b1, 8, 1'b0);
        n_checks++;
        if (got8.size() !== 1 || got8[0].data !== d || got8[0].ferr !== 1'b0)
            $display("FAIL glitch_recover: pulses=%0d data=%h, want 1/%h", got8.size(),
                     (got8.size() > 0) ? got8[0].data : 8'hxx, d);
        else n_pass++;
        got8.delete(); exp8.delete();
    endtask

    task automatic test_frame_err();
        wait_tick();
        send_frame(8'h3C, 8, 16, 1'b0, 1'b0);
        drive(1'b1, 16, 1'b0);
        n_checks++;
        if (frame_err !== 1'b1 || dout !== 8'h3C)
            $display("FAIL ferr_set: dout=%h ferr=%b, want 3C/1", dout, frame_err);
        else n_pass++;
        send_frame(8'h81, 8, 16, 1'b1, 1'b0);
        drive(1'b1, 8, 1'b0);
        n_checks++;
        if (got8.size() !== 2) $display("FAIL ferr_count: %0d pulses, want 2", got8.size());
        else n_pass++;
        for (int i = 0; i < got8.size() && i < exp8.size(); i++) begin
            n_checks++;
            if (got8[i].data !== exp8[i].data || got8[i].ferr !== exp8[i].ferr)
                $display("FAIL ferr_frame%0d: data=%h ferr=%b, want %h/%b", i,
                         got8[i].data, got8[i].ferr, exp8[i].data, exp8[i].ferr);
            else n_pass++;
        end
        got8.delete(); exp8.delete();
    endtask

    task automatic test_back_to_back();
        wait_tick();
        send_frame(8'h00, 8, 16, 1'b1, 1'b0);
        send_frame(8'hFF, 8, 16, 1'b1, 1'b0);
        send_frame(8'h55, 8, 16, 1'b1, 1'b0);
        drive(1'b1, 8, 1'b0);
        n_checks++;
        if (got8.size() !== 3) $display("FAIL b2b_count: %0d pulses, want 3", got8.size());
        else n_pass++;
        for (int i = 0; i < got8.size() && i < exp8.size(); i++) begin
            n_checks++;
            if (got8[i] !== exp8[i])
                $display("FAIL b2b_frame%0d: data=%h ferr=%b tick=%0d, want %h/%b/%0d", i,
                         got8[i].data, got8[i].ferr, got8[i].tick, exp8[i].data, exp8[i].ferr, exp8[i].tick);
            else n_pass++;
        end
        got8.delete(); exp8.delete();
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'h96;
        wait_tick();
        drive(1'b0, 16, 1'b0);
        for (int i = 0; i < 4; i++) drive(d[i], 16, 1'b0);
        drive(d[4], 8, 1'b0);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (dout !== 8'h00 || frame_err !== 1'b0 || rx_done_tick !== 1'b0)
            $display("FAIL midreset_outputs: dout=%h ferr=%b done=%b, want 00/0/0", dout, frame_err, rx_done_tick);
        else n_pass++;
        model_dout = 8'h00;
        model_ferr = 1'b0;
        rx = 1'b1;
        reset_n = 1'b1;
        drive(1'b1, 32, 1'b0);
        n_checks++;
        if (got8.size() !== 0 || dout !== model_dout)
            $display("FAIL midreset_no_done: pulses=%0d dout=%h, want 0/%h", got8.size(), dout, model_dout);
        else n_pass++;
        send_frame(d, 8, 16, 1'b1, 1'b0);
        drive(1'b1, 8, 1'b0);
        n_checks++;
        if (got8.size() !== 1 || got8[0] !== exp8[0])
            $display("FAIL midreset_recover: pulses=%0d data=%h, want 1/96", got8.size(),
                     (got8.size() > 0) ? got8[0].data : 8'hxx);
        else n_pass++;
        got8.delete(); exp8.delete(); got7.delete();
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            wait_tick();
            send_frame(8'($urandom), 8, 16, ($urandom_range(0, 3) != 0), 1'b0);
            drive(1'b1, $urandom_range(0, 8), 1'b0);
        end
        drive(1'b1, 16, 1'b0);
        n_checks++;
        if (got8.size() !== exp8.size())
            $display("FAIL rand_count: %0d pulses, want %0d", got8.size(), exp8.size());
        else n_pass++;
        for (int i = 0; i < got8.size() && i < exp8.size(); i++) begin
            n_checks++;
            if (got8[i] !== exp8[i])
                $display("FAIL rand_frame%0d: data=%h ferr=%b tick=%0d, want %h/%b/%0d", i,
                         got8[i].data, got8[i].ferr, got8[i].tick, exp8[i].data, exp8[i].ferr, exp8[i].tick);
            else n_pass++;
        end
        n_checks++;
        if (dout !== model_dout || frame_err !== model_ferr)
            $display("FAIL rand_hold: dout=%h ferr=%b, want %h/%b", dout, frame_err, model_dout, model_ferr);
        else n_pass++;
        got8.delete(); exp8.delete();
    endtask

    task automatic test_dbit7();
        wait_tick();
        send_frame(8'h5A, 7, 32, 1'b1, 1'b1);
        drive(1'b1, 16, 1'b1);
        n_checks++;
        if (got7.size() !== 1 || got7[0] !== exp7[0])
            $display("FAIL dbit7_frame: pulses=%0d data=%h tick=%0d, want 1/5A/%0d", got7.size(),
                     (got7.size() > 0) ? got7[0].data : 8'hxx, (got7.size() > 0) ? got7[0].tick : -1, exp7[0].tick);
        else n_pass++;
        n_checks++;
        if (got8.size() !== 0) $display("FAIL dbit7_isolation: %0d pulses on 8-bit rx, want 0", got8.size());
        else n_pass++;
        got7.delete(); exp7.delete(); got8.delete();
    endtask

    task automatic test_break();
        int start;
        wait_tick();
        start = tick_cnt;
        drive(1'b0, 480, 1'b0);
        // A held-low line restarts immediately after each frame, so frames repeat every 8+16*8+16 ticks.
        for (int k = 1; k <= 3; k++) exp8.push_back('{8'h00, 1'b1, start + 152 * k});
        n_checks++;
        if (got8.size() !== 3) $display("FAIL break_count: %0d pulses, want 3", got8.size());
        else n_pass++;
        for (int i = 0; i < got8.size() && i < exp8.size(); i++) begin
            n_checks++;
            if (got8[i] !== exp8[i])
                $display("FAIL break_frame%0d: data=%h ferr=%b tick=%0d, want %h/%b/%0d", i,
                         got8[i].data, got8[i].ferr, got8[i].tick, exp8[i].data, exp8[i].ferr, exp8[i].tick);
            else n_pass++;
        end
        rx = 1'b1;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        got8.delete(); exp8.delete();
        drive(1'b1, 200, 1'b0);
        n_checks++;
        if (got8.size() !== 0 || wide_pulses !== 0)
            $display("FAIL final_quiet: pulses=%0d wide=%0d, want 0/0", got8.size(), wide_pulses);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        test_dbit7();
        test_break();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
